// File: rtl/control_sequencer.sv
// Multicycle run/step/halt control unit: one-hot phase counter, decode of the
// current instruction into phase-qualified write enables, latched flags and a retire counter.
module control_sequencer #(
  parameter int WIDTH  = 16,
  parameter int NPHASE = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exec,
  input  logic              step,
  input  logic [WIDTH-1:0]  instruction,
  input  logic              S,
  input  logic              Z,
  input  logic              C,
  input  logic              V,
  output logic [NPHASE-1:0] phase,
  output logic              running,
  output logic              halted,
  output logic              ir_e,
  output logic              flag_e,
  output logic              mem_w,
  output logic              genr_w,
  output logic              pc_e,
  output logic              branch_taken,
  output logic [3:0]        flags_q,
  output logic [CNT_W-1:0]  instr_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;
  localparam logic [NPHASE-1:0] PHASE_P0 = {{(NPHASE-1){1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic [NPHASE-1:0] phase_q, phase_d;
  logic              stop_pending_q, stop_pending_d;
  logic [3:0]        flag_reg_q, flag_reg_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [1:0] op_s;
  logic [2:0] r1_s, r2_s;
  logic [3:0] alu_s;
  logic is_alu_s, is_cmp_s, is_in_s, is_hlt_s, is_ld_s, is_st_s, is_li_s, is_b_s, is_bcc_s;
  logic cond_s, running_s, active_s, halt_now_s;
  logic p_fetch_s, p_exec_s, p_mem_s, p_wb_s;
  logic unused_s;

  assign op_s  = instruction[WIDTH-1 -: 2];
  assign r1_s  = instruction[WIDTH-3 -: 3];
  assign r2_s  = instruction[WIDTH-6 -: 3];
  assign alu_s = instruction[7:4];
  assign unused_s = ^instruction;

  assign is_alu_s = (op_s == 2'b11) &&
                    ((alu_s <= 4'd6) || ((alu_s >= 4'd8) && (alu_s <= 4'd11)));
  assign is_cmp_s = (op_s == 2'b11) && (alu_s == 4'b0101);
  assign is_in_s  = (op_s == 2'b11) && (alu_s == 4'b1100);
  assign is_hlt_s = (op_s == 2'b11) && (alu_s == 4'b1111);
  assign is_ld_s  = (op_s == 2'b00);
  assign is_st_s  = (op_s == 2'b01);
  assign is_li_s  = (op_s == 2'b10) && (r1_s == 3'b000);
  assign is_b_s   = (op_s == 2'b10) && (r1_s == 3'b100);
  assign is_bcc_s = (op_s == 2'b10) && (r1_s == 3'b111);

  // Branch condition evaluated from latched flags {S,Z,C,V}
  always_comb begin
    cond_s = 1'b0;
    case (r2_s)
      3'b000:  cond_s = flag_reg_q[2];
      3'b001:  cond_s = flag_reg_q[3] ^ flag_reg_q[0];
      3'b010:  cond_s = flag_reg_q[2] | (flag_reg_q[3] ^ flag_reg_q[0]);
      3'b011:  cond_s = ~flag_reg_q[2];
      default: cond_s = 1'b0;
    endcase
  end

  assign running_s  = (state_q == ST_RUN) || (state_q == ST_STEP);
  // rst gating keeps every enable quiet during the reset cycle itself
  assign active_s   = rst & running_s;
  assign p_fetch_s  = phase_q[0];
  assign p_exec_s   = phase_q[2];
  assign p_mem_s    = phase_q[NPHASE-2];
  assign p_wb_s     = phase_q[NPHASE-1];
  assign halt_now_s = active_s & p_exec_s & is_hlt_s;

  assign ir_e         = active_s & p_fetch_s;
  assign flag_e       = active_s & p_exec_s & is_alu_s;
  assign mem_w        = active_s & p_mem_s & is_st_s;
  assign genr_w       = active_s & p_wb_s &
                        ((is_alu_s & ~is_cmp_s) | is_in_s | is_ld_s | is_li_s);
  assign pc_e         = active_s & p_wb_s & ~is_hlt_s;
  assign branch_taken = active_s & p_wb_s & (is_b_s | (is_bcc_s & cond_s));

  assign phase       = phase_q;
  assign running     = running_s;
  assign halted      = (state_q == ST_HALT);
  assign flags_q     = flag_reg_q;
  assign instr_count = count_q;

  // Run-control next state, stop request and phase rotation
  always_comb begin
    state_d        = state_q;
    stop_pending_d = stop_pending_q;
    case (state_q)
      ST_IDLE: begin
        if (exec) begin
          state_d = ST_RUN;
        end else if (step) begin
          state_d = ST_STEP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        stop_pending_d = stop_pending_q | exec;
        if (halt_now_s) begin
          state_d        = ST_HALT;
          stop_pending_d = 1'b0;
        end else if (p_wb_s && stop_pending_q) begin
          state_d        = ST_IDLE;
          stop_pending_d = 1'b0;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_STEP: begin
        if (halt_now_s) begin
          state_d = ST_HALT;
        end else if (exec) begin
          state_d = ST_RUN;
        end else if (p_wb_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_STEP;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase

    if (running_s && !halt_now_s) begin
      phase_d = {phase_q[NPHASE-2:0], phase_q[NPHASE-1]};
    end else begin
      phase_d = PHASE_P0;
    end

    if (flag_e) begin
      flag_reg_d = {S, Z, C, V};
    end else begin
      flag_reg_d = flag_reg_q;
    end

    if (active_s && p_wb_s) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      phase_q        <= PHASE_P0;
      stop_pending_q <= 1'b0;
      flag_reg_q     <= 4'b0000;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      stop_pending_q <= stop_pending_d;
      flag_reg_q     <= flag_reg_d;
      count_q        <= count_d;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios plus randomized
// traffic scored against a cycle-level behavioural model.
module tb_control_sequencer;

  localparam int NP = 5;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STEP = 2;
  localparam int M_HALT = 3;

  logic clk, rst, exec, step, S, Z, C, V;
  logic [15:0] instruction;
  logic [NP-1:0] phase;
  logic running, halted, ir_e, flag_e, mem_w, genr_w, pc_e, branch_taken;
  logic [3:0] flags_q;
  logic [15:0] instr_count;
  logic [5:0] en_s;

  int checks = 0;
  int errors = 0;

  int m_mode = M_IDLE;
  int m_ph = 0;
  logic m_pend = 1'b0;
  logic [3:0] m_flags = 4'b0000;
  logic [15:0] m_cnt = 16'd0;

  logic [15:0] tbl [0:13] = '{16'hC000, 16'hC050, 16'hC0C0, 16'hC0D0, 16'h0000, 16'h4000,
                              16'h8000, 16'hA000, 16'hB800, 16'hB900, 16'hBA00, 16'hBB00,
                              16'hBC00, 16'hC070};

  assign en_s = {ir_e, flag_e, mem_w, genr_w, pc_e, branch_taken};

  control_sequencer #(.WIDTH(16), .NPHASE(NP), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .exec(exec), .step(step), .instruction(instruction),
    .S(S), .Z(Z), .C(C), .V(V), .phase(phase), .running(running), .halted(halted),
    .ir_e(ir_e), .flag_e(flag_e), .mem_w(mem_w), .genr_w(genr_w), .pc_e(pc_e),
    .branch_taken(branch_taken), .flags_q(flags_q), .instr_count(instr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected {ir,flag,mem_w,genr_w,pc,branch} from the instruction-class rules
  function automatic logic [5:0] exp_en(int mode, int ph, logic r, logic [15:0] ins,
                                        logic [3:0] fl);
    logic [1:0] op;
    logic [2:0] r1, r2;
    logic [3:0] a;
    logic alu, in_c, hlt, ld, st, li, b, bcc, cond, wb;
    if (!r || !(mode == M_RUN || mode == M_STEP)) return 6'b000000;
    op = ins[15:14]; r1 = ins[13:11]; r2 = ins[10:8]; a = ins[7:4];
    alu  = (op == 2'd3) && ((a < 4'd7) || (a >= 4'd8 && a < 4'd12));
    in_c = (op == 2'd3) && (a == 4'd12);
    hlt  = (op == 2'd3) && (a == 4'd15);
    ld = (op == 2'd0); st = (op == 2'd1);
    li = (op == 2'd2) && (r1 == 3'd0);
    b  = (op == 2'd2) && (r1 == 3'd4);
    bcc = (op == 2'd2) && (r1 == 3'd7);
    case (r2)
      3'd0: cond = fl[2];
      3'd1: cond = fl[3] != fl[0];
      3'd2: cond = fl[2] || (fl[3] != fl[0]);
      3'd3: cond = !fl[2];
      default: cond = 1'b0;
    endcase
    wb = (ph == NP - 1);
    return {ph == 0, ph == 2 && alu, ph == NP - 2 && st,
            wb && ((alu && a != 4'd5) || in_c || ld || li), wb && !hlt, wb && (b || (bcc && cond))};
  endfunction

  task automatic apply(input logic e, input logic s, input logic r, input logic [15:0] ins,
                       input logic [3:0] fl);
    exec = e; step = s; rst = r; instruction = ins; {S, Z, C, V} = fl;
    #1;
  endtask

  // Advance the model across the coming rising edge, then move to the next falling edge
  task automatic clock();
    logic [5:0] ee;
    logic act, hlt;
    ee  = exp_en(m_mode, m_ph, rst, instruction, m_flags);
    act = rst && (m_mode == M_RUN || m_mode == M_STEP);
    hlt = (instruction[15:14] == 2'd3) && (instruction[7:4] == 4'd15) && m_ph == 2;
    if (!rst) begin
      m_mode = M_IDLE; m_ph = 0; m_pend = 1'b0; m_flags = 4'b0000; m_cnt = 16'd0;
    end else begin
      if (ee[4]) m_flags = {S, Z, C, V};
      if (act && m_ph == NP - 1) m_cnt = m_cnt + 16'd1;
      case (m_mode)
        M_IDLE: if (exec) m_mode = M_RUN; else if (step) m_mode = M_STEP;
        M_RUN: begin
          if (hlt) begin m_mode = M_HALT; m_pend = 1'b0; end
          else if (m_ph == NP - 1 && m_pend) begin m_mode = M_IDLE; m_pend = 1'b0; end
          else m_pend = m_pend | exec;
        end
        M_STEP: begin
          if (hlt) m_mode = M_HALT;
          else if (exec) m_mode = M_RUN;
          else if (m_ph == NP - 1) m_mode = M_IDLE;
        end
        default: ;
      endcase
      m_ph = (act && !hlt) ? (m_ph + 1) % NP : 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    for (int c = 0; c < 2; c++) begin
      apply(1'b0, 1'b0, 1'b0, 16'h0000, 4'b0000);
      clock();
    end
  endtask

  task automatic test_reset();
    do_reset();
    apply(1'b0, 1'b0, 1'b1, 16'hC000, 4'b1111);
    checks++;
    if (phase !== 5'b00001 || running !== 1'b0 || halted !== 1'b0) begin
      errors++; $display("FAIL reset_state: phase=%b running=%b halted=%b required 00001/0/0", phase, running, halted);
    end
    checks++;
    if (en_s !== 6'b000000 || flags_q !== 4'b0000 || instr_count !== 16'd0) begin
      errors++; $display("FAIL reset_values: en=%b flags=%b cnt=%0d required 0/0/0", en_s, flags_q, instr_count);
    end
    clock();
  endtask

  task automatic test_add();
    do_reset();
    for (int c = 0; c < 7; c++) begin
      apply(c == 0 || c == 2, 1'b0, 1'b1, 16'hC000, (c == 3) ? 4'b0100 : 4'b0000);
      if (c == 1) begin
        checks++;
        if (ir_e !== 1'b1 || phase !== 5'b00001 || running !== 1'b1) begin
          errors++; $display("FAIL add_fetch: ir_e=%b phase=%b running=%b required 1/00001/1", ir_e, phase, running);
        end
      end
      if (c == 3) begin
        checks++;
        if (flag_e !== 1'b1) begin errors++; $display("FAIL add_flag_e: got %b required 1", flag_e); end
      end
      if (c == 4) begin
        checks++;
        if (flags_q !== 4'b0100) begin errors++; $display("FAIL add_flags_q: got %b required 0100", flags_q); end
      end
      if (c == 5) begin
        checks++;
        if (genr_w !== 1'b1 || pc_e !== 1'b1) begin
          errors++; $display("FAIL add_wb: genr_w=%b pc_e=%b required 1/1", genr_w, pc_e);
        end
      end
      if (c == 6) begin
        checks++;
        if (instr_count !== 16'd1 || running !== 1'b0) begin
          errors++; $display("FAIL add_retire: cnt=%0d running=%b required 1/0", instr_count, running);
        end
      end
      clock();
    end
  endtask

  task automatic test_cmp_branch();
    for (int k = 0; k < 2; k++) begin
      logic zf;
      zf = (k == 0);
      do_reset();
      for (int c = 0; c < 12; c++) begin
        apply(c == 0 || c == 7, 1'b0, 1'b1, (c < 6) ? 16'hC050 : 16'hB800,
              (c == 3) ? {1'b0, zf, 2'b00} : 4'b0000);
        if (c == 5) begin
          checks++;
          if (genr_w !== 1'b0 || pc_e !== 1'b1) begin
            errors++; $display("FAIL cmp_wb: genr_w=%b pc_e=%b required 0/1", genr_w, pc_e);
          end
        end
        if (c == 10) begin
          checks++;
          if (branch_taken !== zf || pc_e !== 1'b1) begin
            errors++; $display("FAIL be_wb: taken=%b pc_e=%b required %b/1", branch_taken, pc_e, zf);
          end
        end
        if (c == 11) begin
          checks++;
          if (instr_count !== 16'd2 || running !== 1'b0) begin
            errors++; $display("FAIL be_retire: cnt=%0d running=%b required 2/0", instr_count, running);
          end
        end
        clock();
      end
    end
  endtask

  task automatic test_step_st();
    int runs = 0;
    int mws = 0;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      apply(1'b0, c == 0, 1'b1, 16'h4000, 4'b0000);
      if (c >= 1 && running === 1'b1) runs++;
      if (mem_w === 1'b1) mws++;
      if (c == 4) begin
        checks++;
        if (mem_w !== 1'b1) begin errors++; $display("FAIL st_mem_w: got %b required 1 in p3", mem_w); end
      end
      if (c == 6) begin
        checks++;
        if (running !== 1'b0 || phase !== 5'b00001 || instr_count !== 16'd1) begin
          errors++; $display("FAIL step_end: running=%b phase=%b cnt=%0d required 0/00001/1", running, phase, instr_count);
        end
      end
      clock();
    end
    checks++;
    if (runs != 5 || mws != 1) begin
      errors++; $display("FAIL step_len: running cycles=%0d mem_w pulses=%0d required 5/1", runs, mws);
    end
  endtask

  task automatic test_halt();
    int bad = 0;
    do_reset();
    for (int c = 0; c < 15; c++) begin
      apply(c == 0 || c == 10, 1'b0, c != 13, (c < 6) ? 16'hC000 : 16'hC0F0, 4'b0000);
      if (c >= 6 && c <= 12 && (pc_e === 1'b1 || genr_w === 1'b1)) bad++;
      if (c == 9) begin
        checks++;
        if (halted !== 1'b1 || running !== 1'b0 || instr_count !== 16'd1 || phase !== 5'b00001) begin
          errors++; $display("FAIL halt_enter: halted=%b running=%b cnt=%0d phase=%b required 1/0/1/00001", halted, running, instr_count, phase);
        end
      end
      if (c == 12) begin
        checks++;
        if (halted !== 1'b1 || running !== 1'b0) begin
          errors++; $display("FAIL halt_ignore_exec: halted=%b running=%b required 1/0", halted, running);
        end
      end
      if (c == 14) begin
        checks++;
        if (halted !== 1'b0 || running !== 1'b0 || instr_count !== 16'd0) begin
          errors++; $display("FAIL halt_reset: halted=%b running=%b cnt=%0d required 0/0/0", halted, running, instr_count);
        end
      end
      clock();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL halt_wb_enables: %0d cycles with pc_e/genr_w required 0", bad); end
  endtask

  task automatic test_stop_and_abort();
    int gw = 0;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      apply(c == 0 || c == 3, 1'b0, 1'b1, 16'h0000, 4'b0000);
      if (c == 5) begin
        checks++;
        if (genr_w !== 1'b1) begin errors++; $display("FAIL ld_wb: genr_w=%b required 1", genr_w); end
      end
      if (c == 6) begin
        checks++;
        if (running !== 1'b0 || phase !== 5'b00001 || instr_count !== 16'd1) begin
          errors++; $display("FAIL stop_mid: running=%b phase=%b cnt=%0d required 0/00001/1", running, phase, instr_count);
        end
      end
      clock();
    end
    do_reset();
    for (int c = 0; c < 8; c++) begin
      apply(c == 0, 1'b0, c != 4, 16'h0000, 4'b0000);
      if (c >= 4 && genr_w === 1'b1) gw++;
      if (c == 5) begin
        checks++;
        if (running !== 1'b0 || phase !== 5'b00001 || en_s !== 6'b000000 || instr_count !== 16'd0) begin
          errors++; $display("FAIL abort: running=%b phase=%b en=%b cnt=%0d required 0/00001/0/0", running, phase, en_s, instr_count);
        end
      end
      clock();
    end
    checks++;
    if (gw != 0) begin errors++; $display("FAIL abort_genr_w: %0d pulses required 0", gw); end
  endtask

  task automatic test_random();
    logic [15:0] ins;
    logic e, s, r;
    logic [5:0] ee;
    logic [NP-1:0] eph;
    ins = 16'hC000;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (m_ph == 0) begin
        if ($urandom_range(0, 39) == 0) ins = 16'hC0F0;
        else if ($urandom_range(0, 9) == 0) ins = 16'($urandom);
        else ins = tbl[$urandom_range(0, 13)];
      end
      e = ($urandom_range(0, 7) == 0);
      s = ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 79) != 0);
      apply(e, s, r, ins, 4'($urandom));
      ee  = exp_en(m_mode, m_ph, r, ins, m_flags);
      eph = 5'b00001 << m_ph;
      checks++;
      if (phase !== eph) begin errors++; $display("FAIL rnd_phase @%0d: got %b required %b", i, phase, eph); end
      checks++;
      if (running !== (m_mode == M_RUN || m_mode == M_STEP) || halted !== (m_mode == M_HALT)) begin
        errors++; $display("FAIL rnd_mode @%0d: running=%b halted=%b model mode %0d", i, running, halted, m_mode);
      end
      checks++;
      if (en_s !== ee) begin errors++; $display("FAIL rnd_enables @%0d: got %b required %b ins=%h", i, en_s, ee, ins); end
      checks++;
      if (flags_q !== m_flags) begin errors++; $display("FAIL rnd_flags @%0d: got %b required %b", i, flags_q, m_flags); end
      checks++;
      if (instr_count !== m_cnt) begin errors++; $display("FAIL rnd_count @%0d: got %0d required %0d", i, instr_count, m_cnt); end
      clock();
    end
  endtask

  initial begin
    exec = 1'b0; step = 1'b0; rst = 1'b0; instruction = 16'h0000;
    {S, Z, C, V} = 4'b0000;
    #2;
    test_reset();
    test_add();
    test_cmp_branch();
    test_step_st();
    test_halt();
    test_stop_and_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
